// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder: one full-adder reused LSB-first, IDLE/RUN/DONE control
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_x;
    logic             w_y;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    always_comb begin
        w_x = 1'b0;
        w_y = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_cnt == CW'(i)) begin
                w_x = r_a[i];
                w_y = r_b[i];
            end
        end
    end

    assign w_s    = w_x ^ w_y ^ r_carry;
    assign w_c    = (w_x & w_y) | (w_x & r_carry) | (w_y & r_carry);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // Partial result with the current bit merged in; on the last bit this is the full sum.
    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_cnt == CW'(i)) begin
                w_acc_next[i] = w_s;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_c;
                    if (w_last) begin
                        sum     <= w_acc_next;
                        cout    <= w_c;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl at WIDTH=8
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst, start, cin;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] sum;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_done_cyc = 0;
    int         prev_done_cyc = 0;
    logic [8:0] last_res = '0;
    logic [8:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 if (clk_en) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input bit meddle);
        int busy_cnt;
        bit got;
        logic [8:0] exp;
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        exp_q.push_back({1'b0, ia} + {1'b0, ib} + {8'd0, ic});
        @(negedge clk);
        if (meddle) begin
            start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
        end else begin
            start = 1'b0; a = ~ia; b = ~ib; cin = ~ic;
        end
        busy_cnt = 0;
        got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                n_cmp++;
                if ({cout, sum} !== last_res) begin
                    n_err++;
                    $display("FAIL hold_during_run: got %h want %h", {cout, sum}, last_res);
                end
                @(negedge clk);
            end
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL done_timeout: got no done want done within 40 cycles");
            void'(exp_q.pop_front());
        end else begin
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            exp = exp_q.pop_front();
            if ({cout, sum} !== exp) begin
                n_err++;
                $display("FAIL result a=%h b=%h cin=%b: got %h want %h", ia, ib, ic, {cout, sum}, exp);
            end
            last_res = exp;
            n_cmp++;
            if (busy_cnt !== 8 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL busy_cycles: got %0d (busy at done %b) want 8 (0)", busy_cnt, busy);
            end
        end
        if (meddle) begin
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL no_second_op: got busy=%b done=%b want 0 0", busy, done);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1 rst = 1'b1;
        #4;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_clock: got busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy, done, sum, cout);
        end
        clk_en = 1'b1;
        start = 1'b1; a = 8'h11; b = 8'h22;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0) begin
                n_err++;
                $display("FAIL start_in_reset: got busy=%b want 0", busy);
            end
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_op(8'h0F, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_one_cycle: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        clk_en = 1'b0;
        #2 rst = 1'b1;
        #3;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy, done, sum, cout);
        end
        last_res = '0;
        rst = 1'b0;
        #1 clk_en = 1'b1;
    endtask

    task automatic test_wrap();
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_latch();
        run_op(8'h12, 8'h34, 1'b0, 1'b1);
        a = '0; b = '0; cin = 1'b0;
    endtask

    task automatic test_abort();
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL abort_reset: got busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy, done, sum, cout);
        end
        last_res = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL abort_no_done: got done=%b busy=%b want 0 0", done, busy);
            end
        end
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run_op({7'd0, v[2]}, {7'd0, v[1]}, v[0], 1'b0);
            if (i > 0) begin
                n_cmp++;
                if (last_done_cyc - prev_done_cyc !== 10) begin
                    n_err++;
                    $display("FAIL spacing combo %0d: got %0d want 10", i, last_done_cyc - prev_done_cyc);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_async_reset();
        test_wrap();
        test_ignore_latch();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
